// File: rtl/dd_pkg.sv
// -----------------------------------------------------------------------------
// dd_pkg
// Shared definitions for the data-delivery path: packet geometry, the
// FIFO-plus-converter read latency, and the FX3 transfer FSM state type.
// The packet size is also the data generator's dataAvailable threshold, so
// both sides must take it from here.
// -----------------------------------------------------------------------------
package dd_pkg;

    localparam int DD_PACKET_WORDS = 8192;
    localparam int DD_READ_LATENCY = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FX3,
        ST_STREAM,
        ST_FLUSH,
        ST_HOLD
    } fx3_state_t;

    // Width of a down-counter that can hold words-1 plus one spare bit.
    function automatic int ddCounterWidth(input int words);
        return $clog2(words) + 1;
    endfunction

endpackage

// File: rtl/fx3_transfer_controller_strobe_delay_line.sv
// -----------------------------------------------------------------------------
// strobe_delay_line
// Fixed-depth 1-bit shift register. Delays the FIFO read request by the
// read pipeline depth so the FX3 write strobe lines up with valid data.
//
// Ports:
//   clk       in   clock, rising edge
//   nReset    in   asynchronous active-low reset (clears every tap)
//   strobeIn  in   strobe to delay
//   strobeOut out  strobeIn delayed by DEPTH cycles (registered)
// -----------------------------------------------------------------------------
module strobe_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic nReset,
    input  logic strobeIn,
    output logic strobeOut
);

    logic [DEPTH-1:0] taps;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            taps <= '0;
        end else begin
            taps[0] <= strobeIn;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign strobeOut = taps[DEPTH-1];

endmodule

// File: rtl/fx3_transfer_controller.sv
// -----------------------------------------------------------------------------
// fx3_transfer_controller
// Moves whole packets from the sample FIFO to the FX3 slave FIFO. A packet
// starts once the FIFO holds PACKET_WORDS words and the FX3 has a free DMA
// buffer. Exactly PACKET_WORDS reads are then issued, and the FX3 write
// strobe follows them by READ_LATENCY cycles. FIFO full/empty conditions are
// latched as sticky errors for the host status path.
//
// Optional feature (macro DD_WATERMARK_THROTTLE_EN):
//   When defined, fx3Watermark high pauses reads mid-packet (combinational
//   gate on readData, word counter frozen). When undefined, fx3Watermark is
//   ignored and reads are contiguous.
//
// Ports:
//   fx3Clk          in   sole clock, rising edge
//   nReset          in   asynchronous active-low reset
//   collectData     in   capture enabled
//   dataAvailable   in   FIFO holds at least PACKET_WORDS words
//   emptyError      in   FIFO read side empty
//   fullError       in   FIFO read side full
//   fx3Ready        in   FX3 DMA buffer available (FLAGA)
//   fx3Watermark    in   FX3 nearly-full (FLAGB), used only with the macro
//   readData        out  FIFO read request
//   fx3Write        out  FX3 write strobe, active-high (pads invert to SLWR#)
//   packetActive    out  first read through last write of a packet
//   overflowError   out  sticky: FIFO full was seen
//   underflowError  out  sticky: read issued while FIFO empty
//   packetCount     out  completed packets, wraps at 16 bits
// -----------------------------------------------------------------------------
module fx3_transfer_controller
    import dd_pkg::*;
#(
    parameter int PACKET_WORDS = DD_PACKET_WORDS,
    parameter int READ_LATENCY = DD_READ_LATENCY
) (
    input  logic        fx3Clk,
    input  logic        nReset,
    input  logic        collectData,
    input  logic        dataAvailable,
    input  logic        emptyError,
    input  logic        fullError,
    input  logic        fx3Ready,
    input  logic        fx3Watermark,
    output logic        readData,
    output logic        fx3Write,
    output logic        packetActive,
    output logic        overflowError,
    output logic        underflowError,
    output logic [15:0] packetCount
);

    localparam int CNT_W   = ddCounterWidth(PACKET_WORDS);
    localparam int FLUSH_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [CNT_W-1:0]   CNT_LOAD   = CNT_W'(PACKET_WORDS - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(READ_LATENCY - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_ONE  = FLUSH_W'(1);

    fx3_state_t         state;
    logic [CNT_W-1:0]   wordCnt;
    logic [FLUSH_W-1:0] flushCnt;
    logic               streamEn;   // registered: high for every STREAM cycle
    logic               readGate;   // a read actually happens this cycle
    logic               errClear;

`ifdef DD_WATERMARK_THROTTLE_EN
    // FX3 leaves at least READ_LATENCY words of margin below the watermark,
    // so words already in the read pipeline may still be written.
    assign readGate = streamEn & ~fx3Watermark;
`else
    logic unusedWatermark;
    assign unusedWatermark = fx3Watermark;
    assign readGate        = streamEn;
`endif

    assign readData = readGate;

    // Sticky errors are only released while idle with capture switched off,
    // so the host sees them until it deliberately stops collection.
    assign errClear = (state == ST_IDLE) && !collectData;

    always_ff @(posedge fx3Clk or negedge nReset) begin
        if (!nReset) begin
            state        <= ST_IDLE;
            wordCnt      <= '0;
            flushCnt     <= '0;
            streamEn     <= 1'b0;
            packetActive <= 1'b0;
            packetCount  <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (collectData && dataAvailable && !overflowError) begin
                        state <= ST_WAIT_FX3;
                    end
                end

                // fx3Ready wins if collectData drops on the same cycle: the
                // buffer is already granted and the FIFO already holds a packet.
                ST_WAIT_FX3: begin
                    if (fx3Ready) begin
                        state        <= ST_STREAM;
                        streamEn     <= 1'b1;
                        packetActive <= 1'b1;
                        wordCnt      <= CNT_LOAD;
                    end else if (!collectData) begin
                        state <= ST_IDLE;
                    end
                end

                // collectData and fx3Ready are deliberately not looked at:
                // a started packet always runs to completion.
                ST_STREAM: begin
                    if (readGate) begin
                        if (wordCnt == '0) begin
                            state    <= ST_FLUSH;
                            streamEn <= 1'b0;
                            flushCnt <= FLUSH_LOAD;
                        end else begin
                            wordCnt <= wordCnt - CNT_ONE;
                        end
                    end
                end

                // Wait for the words still in the FIFO/converter pipeline.
                ST_FLUSH: begin
                    if (flushCnt == '0) begin
                        state        <= ST_HOLD;
                        packetActive <= 1'b0;
                        packetCount  <= packetCount + 16'd1;
                    end else begin
                        flushCnt <= flushCnt - FLUSH_ONE;
                    end
                end

                // One spare cycle so FLAGA reflects the buffer just filled.
                ST_HOLD: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // A new error on the clearing cycle still sets the flag.
    always_ff @(posedge fx3Clk or negedge nReset) begin
        if (!nReset) begin
            overflowError  <= 1'b0;
            underflowError <= 1'b0;
        end else begin
            overflowError  <= fullError | (overflowError & ~errClear);
            underflowError <= (readGate & emptyError) | (underflowError & ~errClear);
        end
    end

    strobe_delay_line #(
        .DEPTH(READ_LATENCY)
    ) uStrobeDelay (
        .clk      (fx3Clk),
        .nReset   (nReset),
        .strobeIn (readGate),
        .strobeOut(fx3Write)
    );

endmodule

// File: tb/tb_fx3_transfer_controller.sv
// -----------------------------------------------------------------------------
// tb_fx3_transfer_controller
// Randomized bench for fx3_transfer_controller with a 16-word packet. A
// packet-level reference model (reads remaining, end-of-stream timestamp,
// sticky flags) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_fx3_transfer_controller;

    localparam int PW  = 16;
    localparam int LAT = 2;
`ifdef DD_WATERMARK_THROTTLE_EN
    localparam bit THROTTLE = 1'b1;
`else
    localparam bit THROTTLE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nReset;
    logic        collectData, dataAvailable, emptyError, fullError;
    logic        fx3Ready, fx3Watermark;
    logic        readData, fx3Write, packetActive;
    logic        overflowError, underflowError;
    logic [15:0] packetCount;

    fx3_transfer_controller #(
        .PACKET_WORDS(PW),
        .READ_LATENCY(LAT)
    ) dut (
        .fx3Clk        (clk),
        .nReset        (nReset),
        .collectData   (collectData),
        .dataAvailable (dataAvailable),
        .emptyError    (emptyError),
        .fullError     (fullError),
        .fx3Ready      (fx3Ready),
        .fx3Watermark  (fx3Watermark),
        .readData      (readData),
        .fx3Write      (fx3Write),
        .packetActive  (packetActive),
        .overflowError (overflowError),
        .underflowError(underflowError),
        .packetCount   (packetCount)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state
    bit          mWaiting, mStreaming, mOvf, mUnf;
    int          mReadsLeft;
    int          tEnd;            // cycle of the last read of the latest packet
    logic [15:0] mCount;
    bit          rdHist[LAT];     // rdHist[0] = expected read one cycle ago

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic modelReset();
        mWaiting   = 1'b0;
        mStreaming = 1'b0;
        mOvf       = 1'b0;
        mUnf       = 1'b0;
        mReadsLeft = 0;
        tEnd       = -100;
        mCount     = 16'd0;
        for (int i = 0; i < LAT; i++) rdHist[i] = 1'b0;
    endtask

    // Called once per cycle at the falling edge: compare, then advance.
    task automatic modelStep();
        bit expRd, expWr, expAct, mIdle, clr, nOvf, nUnf;
        if (cyc == tEnd + LAT + 1) mCount = mCount + 16'd1;
        expRd  = mStreaming && !(THROTTLE && fx3Watermark);
        expWr  = rdHist[LAT-1];
        expAct = mStreaming || (cyc <= tEnd + LAT);

        checkVal("readData",  {31'b0, readData},       {31'b0, expRd});
        checkVal("fx3Write",  {31'b0, fx3Write},       {31'b0, expWr});
        checkVal("active",    {31'b0, packetActive},   {31'b0, expAct});
        checkVal("overflow",  {31'b0, overflowError},  {31'b0, mOvf});
        checkVal("underflow", {31'b0, underflowError}, {31'b0, mUnf});
        checkVal("pktCount",  {16'b0, packetCount},    {16'b0, mCount});

        mIdle = !mWaiting && !mStreaming && (cyc > tEnd + LAT + 1);
        clr   = mIdle && !collectData;
        nOvf  = fullError || (mOvf && !clr);
        nUnf  = (expRd && emptyError) || (mUnf && !clr);

        if (mStreaming) begin
            if (expRd) begin
                mReadsLeft--;
                if (mReadsLeft == 0) begin
                    mStreaming = 1'b0;
                    tEnd       = cyc;
                end
            end
        end else if (mWaiting) begin
            if (fx3Ready) begin
                mWaiting   = 1'b0;
                mStreaming = 1'b1;
                mReadsLeft = PW;
            end else if (!collectData) begin
                mWaiting = 1'b0;
            end
        end else if (mIdle && collectData && dataAvailable && !mOvf) begin
            mWaiting = 1'b1;
        end

        mOvf = nOvf;
        mUnf = nUnf;
        for (int i = LAT - 1; i > 0; i--) rdHist[i] = rdHist[i-1];
        rdHist[0] = expRd;
        cyc++;
    endtask

    function automatic bit chance(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    task automatic runCycles(input int n, input int pCollect, input int pAvail,
                             input int pReady, input int pFullMille,
                             input int pEmpty, input int pWm);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            collectData   = chance(pCollect);
            dataAvailable = chance(pAvail);
            fx3Ready      = chance(pReady);
            fullError     = int'($urandom_range(999)) < pFullMille;
            emptyError    = chance(pEmpty);
            fx3Watermark  = chance(pWm);
            @(negedge clk);
            modelStep();
        end
    endtask

    task automatic idleInputs();
        collectData   = 1'b0;
        dataAvailable = 1'b0;
        fx3Ready      = 1'b0;
        fullError     = 1'b0;
        emptyError    = 1'b0;
        fx3Watermark  = 1'b0;
    endtask

    // Assert reset between edges, check the outputs dropped without a clock
    // edge, then release at a falling edge with quiet inputs.
    task automatic applyReset();
        @(posedge clk);
        #2;
        nReset = 1'b0;
        #1;
        checkVal("rstRead",   {31'b0, readData},       32'd0);
        checkVal("rstWrite",  {31'b0, fx3Write},       32'd0);
        checkVal("rstActive", {31'b0, packetActive},   32'd0);
        checkVal("rstOvf",    {31'b0, overflowError},  32'd0);
        checkVal("rstUnf",    {31'b0, underflowError}, 32'd0);
        checkVal("rstCount",  {16'b0, packetCount},    32'd0);
        idleInputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        nReset = 1'b1;
        modelReset();
    endtask

    initial begin
        nReset = 1'b1;
        idleInputs();
        modelReset();
        applyReset();

        // Back-to-back packets with everything permanently ready.
        runCycles(60, 100, 100, 100, 0, 0, 0);
        // Ready flag bouncing, occasional empty, watermark noise.
        runCycles(500, 95, 70, 40, 0, 5, 20);
        // Reset in the middle of a packet.
        runCycles(12, 100, 100, 100, 0, 0, 0);
        applyReset();
        // Collection toggling often, rare full errors to latch and clear.
        runCycles(700, 70, 80, 60, 4, 5, 25);
        // Long stretch of heavy watermark activity.
        runCycles(300, 100, 100, 80, 0, 0, 50);

        checkVal("sawPackets", {31'b0, (packetCount != 16'd0)}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fx3_transfer_controller.md
# fx3_transfer_controller

Sequences packet transfers from the sample FIFO to the FX3 slave-FIFO interface in the `fx3Clk` domain. It waits until the data generator reports a full packet buffered and the FX3 reports a free DMA buffer. It then issues exactly `PACKET_WORDS` FIFO reads and aligns the FX3 write strobe to the FIFO-plus-converter read pipeline. It also latches buffer overflow and underflow errors for the host status path.

## Interface
- `PACKET_WORDS`, 8192, words per USB packet; must be a power of two, 16 or more.
- `READ_LATENCY`, 2, `fx3Clk` cycles from `readData` high to the matching `dataOut` word being valid (FIFO q register, then converter register).
- `fx3Clk`  in  1  sole clock; all logic on the rising edge.
- `nReset`  in  1  reset; asynchronous, active-low.
- `collectData`  in  1  capture enabled (synchronous to `fx3Clk`).
- `dataAvailable`  in  1  FIFO holds at least `PACKET_WORDS` words.
- `emptyError`  in  1  FIFO read-side empty.
- `fullError`  in  1  FIFO read-side full.
- `fx3Ready`  in  1  FX3 DMA buffer available (FLAGA).
- `fx3Watermark`  in  1  FX3 partial flag (FLAGB), active-high "nearly full"; used only with the macro defined.
- `readData`  out  1  FIFO read request.
- `fx3Write`  out  1  FX3 write strobe, active-high; pad logic inverts it to SLWR#.
- `packetActive`  out  1  high from the first read to the last write of a packet.
- `overflowError`  out  1  sticky; a FIFO full was seen.
- `underflowError`  out  1  sticky; `readData` was issued while `emptyError` was high.
- `packetCount`  out  16  count of completed packets; wraps from 0xFFFF to 0.

## Operation
- FSM states: IDLE, WAIT_FX3, STREAM, FLUSH, HOLD.
- IDLE → WAIT_FX3 when `collectData && dataAvailable && !overflowError`.
- WAIT_FX3 → STREAM when `fx3Ready`. WAIT_FX3 → IDLE if `collectData` falls first.
- STREAM: `readData` is high on every cycle. A 14-bit down-counter (log2 `PACKET_WORDS`+1 bits) is loaded with `PACKET_WORDS`-1 on entry. STREAM → FLUSH after the cycle in which the counter reads 0.
- FLUSH: lasts `READ_LATENCY` cycles with `readData` low while in-flight writes complete. Then `packetCount` increments and the FSM goes to HOLD.
- HOLD: 1 cycle, allowing the FX3 flag to update, then → IDLE.
- `fx3Write` is `readData` delayed by `READ_LATENCY` through a shift register. Exactly `PACKET_WORDS` strobes occur per packet.
- A packet in progress always completes, even if `collectData` falls; there are no partial packets.
- `overflowError` sets on any cycle with `fullError` high. It clears only in IDLE while `collectData` is low. While it is set, no new packet starts.
- `underflowError` sets when `readData && emptyError`. The read still completes. It has the same clear rule as `overflowError`.
- `fx3Ready` falling mid-packet is ignored; FX3 guarantees the whole buffer once flagged.

## Timing
- Reset values:
  - state IDLE.
  - `readData`, `fx3Write`, `packetActive`, `overflowError`, `underflowError` all 0.
  - `packetCount` 0.
  - shift register 0.
- Entry latency: `dataAvailable` and `fx3Ready` high at cycle N gives IDLE → WAIT_FX3 at N+1, and first `readData` at N+2.
- Packet length: `readData` is high for exactly `PACKET_WORDS` consecutive cycles (without the macro).
- `fx3Write` first rises `READ_LATENCY` cycles after the first `readData`.
- `packetActive` rises with the first `readData` and falls with the last `fx3Write`.
- `packetCount` updates on the FLUSH → HOLD edge.
- Minimum gap between packets: `READ_LATENCY`+3 cycles (FLUSH + HOLD + IDLE + WAIT_FX3).
- Reset asserted mid-packet: all outputs drop asynchronously and the counter is lost. The FIFO is not flushed; that is the generator's responsibility.

## Configuration
- `DD_WATERMARK_THROTTLE_EN` defined:
  - In STREAM, `fx3Watermark` high deasserts `readData` on the same cycle (combinational gate) and freezes the counter.
  - The shift register continues, so in-flight words still write. FX3 watermark is programmed with at least `READ_LATENCY` words of margin.
  - Streaming resumes on the cycle after `fx3Watermark` falls.
  - `PACKET_WORDS` reads are still guaranteed.
- Undefined: `fx3Watermark` is ignored, and reads are contiguous.

## Structure
- Shared package `dd_pkg`:
  - FSM state enum `fx3_state_t`.
  - `DD_PACKET_WORDS` = 8192.
  - `DD_READ_LATENCY` = 2.
  - These are shared with the data generator's `dataAvailable` threshold.
- One sub-module, `strobe_delay_line`: parameterised-depth 1-bit shift register with async reset, producing `fx3Write` from `readData`.

## Test plan
- `PACKET_WORDS`=16, `dataAvailable` and `fx3Ready` held high → `readData` high for 16 cycles, `fx3Write` for 16 cycles lagging by 2, and `packetCount` 0→1.
- `fx3Ready` low for 5 cycles after `dataAvailable` → FSM holds in WAIT_FX3 with no reads; first read 1 cycle after `fx3Ready` rises.
- `collectData` falls at word 7 of 16 → all 16 reads and writes complete, and the FSM returns to IDLE.
- `fullError` pulsed 1 cycle → `overflowError`=1 and no further packets. `collectData` low in IDLE → cleared.
- `emptyError` high during STREAM → `underflowError`=1; packet length is still 16.
- Macro defined, `fx3Watermark` high for 3 cycles at word 8 → `readData` gap of 3 cycles, and the total is still 16 reads and 16 writes.
